plot_receiver: RTL and testbench
================================

// Module: plot_receiver
// PURPOSE
//  Receive end of the pixel-plot interface (x, y, colour, plot strobe) that the display
//  datapath drives. Clips and queues plot commands, then writes them into an on-chip
//  SCREEN_W x SCREEN_H x 3b framebuffer. A raster scanner reads the framebuffer back
//  in address order over a valid/ready stream for the VGA output stage or the bench.
// PARAMETERS
//  SCREEN_W    160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H    120  visible rows; y >= SCREEN_H is clipped
//  FIFO_DEPTH  4    plot command queue entries (power of 2)
//  ADDR_W      15   framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
// PORTS
//  clock      in   1      sole clock, rising edge
//  resetn     in   1      asynchronous, ACTIVE-HIGH reset (despite the name)
//  plot       in   1      plot command valid
//  x          in   8      pixel column
//  y          in   7      pixel row
//  colour     in   3      pixel colour
//  plotReady  out  1      command accepted this cycle when plot && plotReady
//  scanStart  in   1      start a full-frame readback (honoured only in IDLE)
//  scanPixel  out  3      readback colour
//  scanValid  out  1      scanPixel valid
//  scanReady  in   1      consumer accepts scanPixel
//  scanDone   out  1      one-cycle pulse after last pixel accepted
//  dropCount  out  8      number of clipped commands, saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty; scanner IDLE; scanPixel=0, scanValid=0, scanDone=0, dropCount=0.
//   plotReady=1 (it is !full). Arbiter pointer favours drain. Framebuffer not cleared.
//   Reset mid-scan aborts the scan with no scanDone. Queued commands are discarded.
//  Accept: plot && plotReady at edge N. If x<SCREEN_W && y<SCREEN_H, enqueue
//   {addr=y*SCREEN_W+x (ADDR_W bits), colour}. Otherwise drop and dropCount++ (sat 255).
//   plotReady=0 when FIFO holds FIFO_DEPTH entries. There is no enqueue-to-memory bypass.
//   The earliest write of a command accepted at edge N occurs at edge N+1.
//  Memory port: single synchronous port, one op per cycle. Requesters: drain (FIFO
//   non-empty) and scan (state READ). When only one requests, it is granted. When both
//   request, they alternate via a pointer that toggles after each contended grant.
//   A write that is granted pops the FIFO head the same edge.
//  Scanner FSM (scanAddr ADDR_W bits):
//   IDLE    -> READ on scanStart; scanAddr=0. scanStart is ignored in other states.
//   READ    -> CAPTURE when granted; the read of scanAddr is issued. Stays in READ if not granted.
//   CAPTURE -> HOLD; scanPixel<=mem data, scanValid<=1.
//   HOLD    -> waits while !scanReady; scanPixel/scanValid stay stable.
//     On scanReady: scanValid<=0. If scanAddr==SCREEN_W*SCREEN_H-1 -> DONE,
//     else scanAddr++ and -> READ.
//   DONE    -> IDLE; scanDone=1 for exactly this cycle.
//   Uncontended: scanStart at edge N gives scanValid high after edge N+2.
//   Each pixel takes a minimum of 3 cycles.
//  Coherence: a read returns data from every write granted on an earlier edge.
//   A same-address write/read in one cycle cannot occur (single grant).
//  Throughput: the drain gets at least 1 of 2 cycles under contention. It gets every
//   cycle while the scanner is outside READ. Commands are never lost.
// TESTING
//  1 Reset; plot (0,0,101), (159,119,010), (5,1,111); scan with scanReady=1 ->
//    pixel0=101, pixel165=111, pixel19199=010; exactly 19200 valid beats; one scanDone.
//  2 Clip: plot (160,0,*) -> dropCount=1, no framebuffer change. (200,119,*) -> 2.
//    300 clipped plots -> dropCount=255.
//  3 Backpressure: plot every cycle during a scan with scanReady=1 -> FIFO reaches
//    4 and plotReady drops. All accepted commands appear in a later readback.
//  4 Stall: scanReady=0 for 10 cycles in HOLD -> scanValid=1 and scanPixel constant.
//    Next pixel follows 3 cycles after release (uncontended).
//  5 Reset asserted at pixel 50 of a scan -> next cycle scanValid=0, dropCount=0,
//    plotReady=1, no scanDone pulse. Second scanStart restarts at pixel 0.
//  6 scanStart pulsed mid-scan -> ignored; beat count stays 19200; one scanDone.

Source files
------------

// File: rtl/plot_receiver_if.sv
// Pixel-plot command bus plus the framebuffer readback stream.
// master drives plot commands and scan control; slave is the receiver.
interface plot_receiver_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plotReady;
  logic       scanStart;
  logic [2:0] scanPixel;
  logic       scanValid;
  logic       scanReady;
  logic       scanDone;
  logic [7:0] dropCount;

  modport master (output plot, x, y, colour, scanStart, scanReady,
                  input  plotReady, scanPixel, scanValid, scanDone, dropCount);
  modport slave  (input  plot, x, y, colour, scanStart, scanReady,
                  output plotReady, scanPixel, scanValid, scanDone, dropCount);
endinterface

// File: rtl/plot_receiver.sv
// Plot receiver: clip + queue plot commands, write them into a 3b framebuffer,
// and stream the framebuffer back in address order over valid/ready.
module plot_receiver #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic           clock,
  input  logic           resetn,   // active-high asynchronous reset
  plot_receiver_if.slave bus
);
  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, HOLD, DONE} scan_st_e;

  // command queue
  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_q, rd_q, wr_d, rd_d;
  logic [PW:0]   count;
  logic          full, empty, accept, in_range, push;
  cmd_t          head, cmd_in;

  assign count    = wr_q - rd_q;
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (wr_q == rd_q);
  assign head     = fifo_mem[rd_q[PW-1:0]];
  assign accept   = bus.plot && !full;
  assign in_range = (int'(bus.x) < SCREEN_W) && (int'(bus.y) < SCREEN_H);
  assign push     = accept && in_range;
  assign cmd_in   = '{addr:   ADDR_W'(bus.y) * ADDR_W'(SCREEN_W) + ADDR_W'(bus.x),
                      colour: bus.colour};

  // single-port arbitration between drain (write) and scanner (read)
  scan_st_e          state_q, state_d;
  logic              prio_scan_q, prio_scan_d;
  logic              drain_req, scan_req, grant_drain, grant_scan;

  assign drain_req   = !empty;
  assign scan_req    = (state_q == READ);
  assign grant_drain = drain_req && (!scan_req || !prio_scan_q);
  assign grant_scan  = scan_req && (!drain_req || prio_scan_q);
  assign prio_scan_d = (drain_req && scan_req) ? !prio_scan_q : prio_scan_q;
  assign wr_d        = push ? wr_q + 1'b1 : wr_q;
  assign rd_d        = grant_drain ? rd_q + 1'b1 : rd_q;

  // framebuffer is deliberately never cleared
  logic [2:0]        fb_mem [NPIX];
  logic [2:0]        rd_data_q;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_q[PW-1:0]] <= cmd_in;
    if (grant_drain) fb_mem[head.addr] <= head.colour;
    if (grant_scan)  rd_data_q <= fb_mem[scan_addr_q];
  end

  // scanner
  logic [2:0] pix_q, pix_d;
  logic       vld_q, vld_d;
  logic [7:0] drop_q, drop_d;

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    pix_d       = pix_q;
    vld_d       = vld_q;
    unique case (state_q)
      IDLE: if (bus.scanStart) begin
        state_d     = READ;
        scan_addr_d = '0;
      end
      READ:    if (grant_scan) state_d = CAPTURE;
      CAPTURE: begin
        pix_d   = rd_data_q;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (bus.scanReady) begin
        vld_d = 1'b0;
        if (scan_addr_q == LAST_ADDR) state_d = DONE;
        else begin
          scan_addr_d = scan_addr_q + 1'b1;
          state_d     = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drop_d = (accept && !in_range && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      wr_q        <= '0;
      rd_q        <= '0;
      prio_scan_q <= 1'b0;
      state_q     <= IDLE;
      scan_addr_q <= '0;
      pix_q       <= '0;
      vld_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      prio_scan_q <= prio_scan_d;
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      pix_q       <= pix_d;
      vld_q       <= vld_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.plotReady = !full;
  assign bus.scanPixel = pix_q;
  assign bus.scanValid = vld_q;
  assign bus.scanDone  = (state_q == DONE);
  assign bus.dropCount = drop_q;
endmodule

// File: tb/tb_plot_receiver.sv
// Randomized bench for plot_receiver on a reduced screen; a plain pixel array
// plus a saturating drop counter serve as the reference.
module tb_plot_receiver;
  localparam int W = 20;
  localparam int H = 12;
  localparam int N = W * H;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  plot_receiver_if bus ();

  plot_receiver #(.SCREEN_W(W), .SCREEN_H(H), .FIFO_DEPTH(4), .ADDR_W(15)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] model_fb [N];
  int         model_drop = 0;
  logic [2:0] beats [$];
  int         done_cnt = 0;
  int         ready_low_seen = 0;
  int         scan_d0;
  bit         scan_ok;

  always @(negedge clock) begin
    if (!resetn) begin
      if (bus.scanValid && bus.scanReady) beats.push_back(bus.scanPixel);
      if (bus.scanDone) done_cnt++;
    end
  end

  function automatic int scan_mismatches();
    int bad = 0;
    if (beats.size() != N) return -1;
    for (int i = 0; i < N; i++) if (beats[i] !== model_fb[i]) bad++;
    return bad;
  endfunction

  task automatic send_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bit got = 0;
    bus.plot = 1'b1; bus.x = px; bus.y = py; bus.colour = pc;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clock);
      if (bus.plotReady) got = 1; else ready_low_seen++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL plot_timeout: plotReady stayed low, required high within 50 cycles");
    end
    @(posedge clock); #1;
    bus.plot = 1'b0;
    if (int'(px) < W && int'(py) < H) model_fb[int'(py) * W + int'(px)] = pc;
    else if (model_drop < 255) model_drop++;
  endtask

  task automatic wait_drain();
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic run_scan(input int rdy_pct, input int pulse_at);
    beats.delete();
    scan_d0 = done_cnt;
    scan_ok = 0;
    for (int c = 0; c < 20 * N && !scan_ok; c++) begin
      @(posedge clock); #1;
      bus.scanStart = (c == 0) || (c == pulse_at);
      bus.scanReady = ($urandom_range(99) < rdy_pct);
      if (done_cnt != scan_d0) scan_ok = 1;
    end
    bus.scanStart = 1'b0;
    bus.scanReady = 1'b0;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.plotReady !== 1'b1) begin n_fail++; $display("FAIL reset_plotReady: got %b want 1", bus.plotReady); end
    n_checks++; if (bus.scanValid !== 1'b0) begin n_fail++; $display("FAIL reset_scanValid: got %b want 0", bus.scanValid); end
    n_checks++; if (bus.scanDone !== 1'b0)  begin n_fail++; $display("FAIL reset_scanDone: got %b want 0", bus.scanDone); end
    n_checks++; if (bus.scanPixel !== 3'd0) begin n_fail++; $display("FAIL reset_scanPixel: got %0d want 0", bus.scanPixel); end
    n_checks++; if (bus.dropCount !== 8'd0) begin n_fail++; $display("FAIL reset_dropCount: got %0d want 0", bus.dropCount); end
    @(posedge clock); #1;
    resetn = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    for (int a = 0; a < N; a++) send_plot(8'(a % W), 7'(a / W), 3'($urandom_range(7)));
    send_plot(8'd0, 7'd0, 3'b101);
    send_plot(8'(W - 1), 7'(H - 1), 3'b010);
    send_plot(8'd5, 7'd1, 3'b111);
    wait_drain();
    run_scan(100, -1);
    n_checks++; if (!scan_ok) begin n_fail++; $display("FAIL basic_timeout: scanDone not seen, required within budget"); end
    n_checks++; if (beats.size() != N) begin n_fail++; $display("FAIL basic_beats: got %0d want %0d", beats.size(), N); end
    n_checks++; if (done_cnt - scan_d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - scan_d0); end
    if (beats.size() == N) begin
      n_checks++; if (beats[0] !== 3'b101) begin n_fail++; $display("FAIL basic_pix0: got %b want 101", beats[0]); end
      n_checks++; if (beats[W + 5] !== 3'b111) begin n_fail++; $display("FAIL basic_pix_5_1: got %b want 111", beats[W + 5]); end
      n_checks++; if (beats[N - 1] !== 3'b010) begin n_fail++; $display("FAIL basic_pix_last: got %b want 010", beats[N - 1]); end
    end
    bad = scan_mismatches();
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_data: %0d pixel mismatches, want 0", bad); end
  endtask

  task automatic test_clip();
    int bad;
    send_plot(8'(W), 7'd0, 3'd3);
    n_checks++; if (bus.dropCount !== 8'(model_drop)) begin n_fail++; $display("FAIL clip_x: got %0d want %0d", bus.dropCount, model_drop); end
    send_plot(8'd200, 7'(H - 1), 3'd4);
    n_checks++; if (bus.dropCount !== 8'(model_drop)) begin n_fail++; $display("FAIL clip_x200: got %0d want %0d", bus.dropCount, model_drop); end
    send_plot(8'd0, 7'(H), 3'd6);
    n_checks++; if (bus.dropCount !== 8'(model_drop)) begin n_fail++; $display("FAIL clip_y: got %0d want %0d", bus.dropCount, model_drop); end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1) == 1) send_plot(8'($urandom_range(255, W)), 7'($urandom_range(127)), 3'($urandom_range(7)));
      else                        send_plot(8'($urandom_range(255)), 7'($urandom_range(127, H)), 3'($urandom_range(7)));
    end
    n_checks++; if (bus.dropCount !== 8'd255 || model_drop != 255) begin n_fail++; $display("FAIL clip_saturate: got %0d want 255", bus.dropCount); end
    wait_drain();
    run_scan(100, -1);
    bad = scan_mismatches();
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clip_fb_unchanged: %0d pixel mismatches, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int bad;
    ready_low_seen = 0;
    fork
      run_scan(100, -1);
      for (int i = 0; i < 60; i++) send_plot(8'($urandom_range(W - 1)), 7'($urandom_range(H - 1)), 3'($urandom_range(7)));
    join
    n_checks++; if (ready_low_seen == 0) begin n_fail++; $display("FAIL b2b_full: plotReady never low, required to drop when queue full"); end
    n_checks++; if (beats.size() != N || done_cnt - scan_d0 != 1) begin n_fail++; $display("FAIL b2b_scan: got %0d beats %0d done want %0d/1", beats.size(), done_cnt - scan_d0, N); end
    wait_drain();
    run_scan(60, -1);
    bad = scan_mismatches();
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_data: %0d pixel mismatches, want 0", bad); end
  endtask

  task automatic test_stall();
    logic [2:0] p0;
    int k;
    bit seen = 0;
    beats.delete();
    scan_d0 = done_cnt;
    @(posedge clock); #1;
    bus.scanStart = 1'b1; bus.scanReady = 1'b0;
    @(posedge clock); #1;
    bus.scanStart = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin @(negedge clock); if (bus.scanValid) seen = 1; end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_first_valid: scanValid=0 want 1 within 20 cycles"); end
    p0 = bus.scanPixel;
    n_checks++; if (p0 !== model_fb[0]) begin n_fail++; $display("FAIL stall_pix0: got %0d want %0d", p0, model_fb[0]); end
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      n_checks++;
      if (bus.scanValid !== 1'b1 || bus.scanPixel !== p0) begin
        n_fail++; $display("FAIL stall_hold: got valid=%b pix=%0d want 1/%0d", bus.scanValid, bus.scanPixel, p0);
      end
    end
    @(posedge clock); #1;
    bus.scanReady = 1'b1;
    @(negedge clock);
    k = 0;
    for (int t = 1; t <= 10 && k == 0; t++) begin @(negedge clock); if (bus.scanValid) k = t; end
    n_checks++; if (k != 3) begin n_fail++; $display("FAIL stall_release_gap: got %0d cycles want 3", k); end
    n_checks++; if (bus.scanPixel !== model_fb[1]) begin n_fail++; $display("FAIL stall_pix1: got %0d want %0d", bus.scanPixel, model_fb[1]); end
    seen = 0;
    for (int t = 0; t < 10 * N && !seen; t++) begin @(posedge clock); #1; if (done_cnt != scan_d0) seen = 1; end
    bus.scanReady = 1'b0;
    n_checks++; if (!seen || beats.size() != N) begin n_fail++; $display("FAIL stall_complete: got %0d beats want %0d", beats.size(), N); end
  endtask

  task automatic test_reset_mid_scan();
    int bad, d0;
    bit hit = 0;
    beats.delete();
    d0 = done_cnt;
    @(posedge clock); #1;
    bus.scanStart = 1'b1; bus.scanReady = 1'b1;
    @(posedge clock); #1;
    bus.scanStart = 1'b0;
    for (int t = 0; t < 10 * N && !hit; t++) begin @(posedge clock); #1; if (beats.size() >= 50) hit = 1; end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach50: got %0d beats want 50", beats.size()); end
    resetn = 1'b1;
    model_drop = 0;
    @(negedge clock);
    n_checks++; if (bus.scanValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", bus.scanValid); end
    n_checks++; if (bus.dropCount !== 8'(model_drop)) begin n_fail++; $display("FAIL rst_mid_drop: got %0d want 0", bus.dropCount); end
    n_checks++; if (bus.plotReady !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus.plotReady); end
    @(posedge clock); #1;
    resetn = 1'b0; bus.scanReady = 1'b0;
    repeat (5) @(posedge clock);
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d pulses want 0", done_cnt - d0); end
    run_scan(70, -1);
    bad = scan_mismatches();
    n_checks++; if (bad != 0 || done_cnt - scan_d0 != 1) begin n_fail++; $display("FAIL rst_mid_rescan: mismatches=%0d done=%0d want 0/1", bad, done_cnt - scan_d0); end
  endtask

  task automatic test_restart_ignored();
    int bad;
    run_scan(80, 100);
    n_checks++; if (beats.size() != N) begin n_fail++; $display("FAIL restart_beats: got %0d want %0d", beats.size(), N); end
    n_checks++; if (done_cnt - scan_d0 != 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", done_cnt - scan_d0); end
    bad = scan_mismatches();
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL restart_data: %0d pixel mismatches, want 0", bad); end
  endtask

  initial begin
    bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.colour = '0;
    bus.scanStart = 1'b0; bus.scanReady = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_back_to_back();
    test_stall();
    test_reset_mid_scan();
    test_restart_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
